// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle CPU controller: state encodings,
// opcodes, ALU function codes and the control-strobe bundle.
package cpu_defs_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OP_W-1:0] OP_OR   = 6'b010010;
  localparam logic [OP_W-1:0] OP_SLT  = 6'b100111;
  localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OP_W-1:0] OP_J    = 6'b111000;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b110;

  typedef struct packed {
    logic             pc_wre;
    logic             branch;
    logic             jump;
    logic             ir_wre;
    logic             ins_mem_rw;
    logic             reg_wre;
    logic             reg_dst;
    logic             alu_src_b;
    logic             m_rd;
    logic             m_wr;
    logic             db_data_src;
    logic             illegal_op;
    logic             halted;
    logic [ALU_W-1:0] alu_op;
  } ctrl_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_ORI, OP_AND, OP_OR, OP_SLT,
      OP_SW, OP_LW, OP_BEQ, OP_J, OP_HALT: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] alu_of(input logic [OP_W-1:0] op);
    case (op)
      OP_SUB, OP_BEQ: return ALU_SUB;
      OP_ORI, OP_OR:  return ALU_OR;
      OP_AND:         return ALU_AND;
      OP_SLT:         return ALU_SLT;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decode: current state plus latched opcode to
// datapath strobes and selects.
module ctrl_decode
  import cpu_defs_pkg::*;
(
  input  state_t            state,
  input  logic [OP_W-1:0]   op,
  input  logic              mem_ready,
  output ctrl_t             ctrl_c
);

  logic is_r;
  logic is_imm;

  assign is_r   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                  (op == OP_OR)  || (op == OP_SLT);
  assign is_imm = (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LW) || (op == OP_SW);

  always_comb begin
    ctrl_c = '0;
    // PCWre marks the last cycle of every instruction
    case (state)
      S_IF: begin
        ctrl_c.ir_wre     = 1'b1;
        ctrl_c.ins_mem_rw = 1'b1;
      end
      S_ID: begin
        if (op == OP_J) begin
          ctrl_c.jump   = 1'b1;
          ctrl_c.pc_wre = 1'b1;
        end else if (!is_legal(op)) begin
          ctrl_c.illegal_op = 1'b1;
          ctrl_c.pc_wre     = 1'b1;
        end
      end
      S_EXE: begin
        ctrl_c.branch = (op == OP_BEQ);
        ctrl_c.pc_wre = (op == OP_BEQ);
      end
      S_MEM: begin
        ctrl_c.m_rd   = (op == OP_LW);
        ctrl_c.m_wr   = (op == OP_SW);
        ctrl_c.pc_wre = (op == OP_SW) && mem_ready;
      end
      S_WB: begin
        ctrl_c.reg_wre = 1'b1;
        ctrl_c.pc_wre  = 1'b1;
      end
      S_HALT: ctrl_c.halted = 1'b1;
      default: ;
    endcase

    // Datapath selects only matter once the instruction is executing
    if (state == S_EXE || state == S_MEM || state == S_WB) begin
      ctrl_c.alu_op      = alu_of(op);
      ctrl_c.alu_src_b   = is_imm;
      ctrl_c.reg_dst     = is_r;
      ctrl_c.db_data_src = (op == OP_LW);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: state machine, opcode latch and retired
// instruction counter around the combinational decode.
module multicycle_ctrl
  import cpu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   opcode,
  input  logic              Zero,
  input  logic              mem_ready,
  output logic              PCWre,
  output logic              Branch,
  output logic              Jump,
  output logic              IRWre,
  output logic              InsMemRW,
  output logic              RegWre,
  output logic              RegDst,
  output logic              ALUSrcB,
  output logic              mRD,
  output logic              mWR,
  output logic              DBDataSrc,
  output logic [ALU_W-1:0]  ALUOp,
  output logic [2:0]        state,
  output logic              halted,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  instr_count
);

  state_t            state_q;
  state_t            state_nxt;
  logic [OP_W-1:0]   op_q;
  logic [CNT_W-1:0]  cnt_q;
  ctrl_t             ctrl_c;

  // Zero only qualifies Branch in the PC-select mux outside this block
  logic unused_zero;
  assign unused_zero = Zero;

  ctrl_decode u_decode (
    .state     (state_q),
    .op        (op_q),
    .mem_ready (mem_ready),
    .ctrl_c    (ctrl_c)
  );

  // State register, opcode latch on ID entry, retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == S_IF) op_q <= opcode;
      if (ctrl_c.pc_wre)   cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IF: state_nxt = S_ID;
      S_ID: begin
        if (op_q == OP_J || !is_legal(op_q)) state_nxt = S_IF;
        else if (op_q == OP_HALT)            state_nxt = S_HALT;
        else                                 state_nxt = S_EXE;
      end
      S_EXE: begin
        if (op_q == OP_BEQ)                        state_nxt = S_IF;
        else if (op_q == OP_LW || op_q == OP_SW)   state_nxt = S_MEM;
        else                                       state_nxt = S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_nxt = (op_q == OP_SW) ? S_IF : S_WB;
      end
      S_WB:   state_nxt = S_IF;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  assign PCWre       = ctrl_c.pc_wre;
  assign Branch      = ctrl_c.branch;
  assign Jump        = ctrl_c.jump;
  assign IRWre       = ctrl_c.ir_wre;
  assign InsMemRW    = ctrl_c.ins_mem_rw;
  assign RegWre      = ctrl_c.reg_wre;
  assign RegDst      = ctrl_c.reg_dst;
  assign ALUSrcB     = ctrl_c.alu_src_b;
  assign mRD         = ctrl_c.m_rd;
  assign mWR         = ctrl_c.m_wr;
  assign DBDataSrc   = ctrl_c.db_data_src;
  assign ALUOp       = ctrl_c.alu_op;
  assign halted      = ctrl_c.halted;
  assign illegal_op  = ctrl_c.illegal_op;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-opcode vector table plus
// hand-written halt and reset corner cases.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        Zero;
  logic        mem_ready;
  logic        PCWre, Branch, Jump, IRWre, InsMemRW, RegWre, RegDst;
  logic        ALUSrcB, mRD, mWR, DBDataSrc, halted, illegal_op;
  logic [2:0]  ALUOp;
  logic [2:0]  state;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .Zero        (Zero),
    .mem_ready   (mem_ready),
    .PCWre       (PCWre),
    .Branch      (Branch),
    .Jump        (Jump),
    .IRWre       (IRWre),
    .InsMemRW    (InsMemRW),
    .RegWre      (RegWre),
    .RegDst      (RegDst),
    .ALUSrcB     (ALUSrcB),
    .mRD         (mRD),
    .mWR         (mWR),
    .DBDataSrc   (DBDataSrc),
    .ALUOp       (ALUOp),
    .state       (state),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         waits;
    int         cyc;
    logic [2:0] fin;
    logic       br;
    logic       jmp;
    int         rw;
    logic       il;
    logic [2:0] alu;
    logic       srcb;
    logic       dst;
    logic       db;
    int         mem;
    logic       mrd;
    logic       mwr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one instruction starting at a negedge in IF; returns at the negedge after it retires.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc, mem_cyc, rw_cnt;
    logic done, mrd_ok, mwr_ok, srcb_exe, f_br, f_j, f_il, f_dst, f_db;
    logic [2:0] f_st, alu_exe;
    logic [31:0] cnt0;
    string tag;
    tag = $sformatf("v%0d_op%b", idx, v.op);
    cnt0 = instr_count;
    cyc = 0; mem_cyc = 0; rw_cnt = 0; done = 1'b0;
    mrd_ok = 1'b1; mwr_ok = 1'b1; srcb_exe = 1'b0; alu_exe = 3'b000;
    f_st = 3'b000; f_br = 1'b0; f_j = 1'b0; f_il = 1'b0; f_dst = 1'b0; f_db = 1'b0;
    chk({tag, "_start_if"}, 32'(state), 32'd0);
    opcode = v.op;
    Zero = v.zero;
    while (!done && cyc < 20) begin
      if (state == 3'd3) begin
        mem_ready = (mem_cyc >= v.waits);
        mem_cyc++;
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (state == 3'd3) begin
        if (mRD !== v.mrd) mrd_ok = 1'b0;
        if (mWR !== v.mwr) mwr_ok = 1'b0;
      end
      if (state == 3'd2) begin
        alu_exe = ALUOp;
        srcb_exe = ALUSrcB;
        opcode = ~v.op;
      end
      if (state == 3'd1) chk({tag, "_aluop_id"}, 32'(ALUOp), 32'd0);
      if (RegWre) rw_cnt++;
      cyc++;
      if (PCWre) begin
        done = 1'b1;
        f_st = state; f_br = Branch; f_j = Jump; f_il = illegal_op;
        f_dst = RegDst; f_db = DBDataSrc;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    chk({tag, "_retired_in_budget"}, 32'(done), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(v.cyc));
    chk({tag, "_final_state"}, 32'(f_st), 32'(v.fin));
    chk({tag, "_branch"}, 32'(f_br), 32'(v.br));
    chk({tag, "_jump"}, 32'(f_j), 32'(v.jmp));
    chk({tag, "_illegal"}, 32'(f_il), 32'(v.il));
    chk({tag, "_regwre_cycles"}, 32'(rw_cnt), 32'(v.rw));
    chk({tag, "_aluop_exe"}, 32'(alu_exe), 32'(v.alu));
    chk({tag, "_alusrcb_exe"}, 32'(srcb_exe), 32'(v.srcb));
    chk({tag, "_regdst"}, 32'(f_dst), 32'(v.dst));
    chk({tag, "_dbdatasrc"}, 32'(f_db), 32'(v.db));
    chk({tag, "_mem_cycles"}, 32'(mem_cyc), 32'(v.mem));
    chk({tag, "_mrd_in_mem"}, 32'(mrd_ok), 32'd1);
    chk({tag, "_mwr_in_mem"}, 32'(mwr_ok), 32'd1);
    chk({tag, "_count_inc"}, instr_count, cnt0 + 32'd1);
    chk({tag, "_back_to_if"}, 32'(state), 32'd0);
  endtask

  initial begin
    //         op         z     w  cyc fin   br    j     rw il    alu     srcb  dst   db   mem mrd   mwr
    vecs[0]  = '{6'b000000, 1'b0, 0, 4, 3'd4, 1'b0, 1'b0, 1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[1]  = '{6'b000001, 1'b0, 0, 4, 3'd4, 1'b0, 1'b0, 1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[2]  = '{6'b000010, 1'b0, 0, 4, 3'd4, 1'b0, 1'b0, 1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[3]  = '{6'b010000, 1'b0, 0, 4, 3'd4, 1'b0, 1'b0, 1, 1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[4]  = '{6'b010001, 1'b0, 0, 4, 3'd4, 1'b0, 1'b0, 1, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[5]  = '{6'b010010, 1'b0, 0, 4, 3'd4, 1'b0, 1'b0, 1, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[6]  = '{6'b100111, 1'b0, 0, 4, 3'd4, 1'b0, 1'b0, 1, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[7]  = '{6'b110001, 1'b0, 2, 7, 3'd4, 1'b0, 1'b0, 1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b0};
    vecs[8]  = '{6'b110000, 1'b0, 0, 4, 3'd3, 1'b0, 1'b0, 0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[9]  = '{6'b110000, 1'b0, 1, 5, 3'd3, 1'b0, 1'b0, 0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1};
    vecs[10] = '{6'b110100, 1'b1, 0, 3, 3'd2, 1'b1, 1'b0, 0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[11] = '{6'b110100, 1'b0, 0, 3, 3'd2, 1'b1, 1'b0, 0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[12] = '{6'b111000, 1'b0, 0, 2, 3'd1, 1'b0, 1'b1, 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[13] = '{6'b101010, 1'b0, 0, 2, 3'd1, 1'b0, 1'b0, 0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

    rst_n = 1'b0;
    opcode = 6'b000000;
    Zero = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_irwre", 32'(IRWre), 32'd1);
    chk("rst_insmemrw", 32'(InsMemRW), 32'd1);
    chk("rst_other_strobes",
        32'({PCWre, Branch, Jump, RegWre, RegDst, ALUSrcB, mRD, mWR, DBDataSrc, halted, illegal_op}),
        32'd0);
    chk("rst_aluop", 32'(ALUOp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_vec(i, vecs[i]);
      if (i == 0) chk("add_after_reset_count", instr_count, 32'd1);
    end

    // halt: holds HALT with all write strobes low
    begin
      logic [31:0] cnt0;
      cnt0 = instr_count;
      opcode = 6'b111111;
      @(negedge clk);
      chk("halt_id", 32'(state), 32'd1);
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("halt_state_%0d", k), 32'(state), 32'd5);
        chk($sformatf("halt_flag_%0d", k), 32'(halted), 32'd1);
        chk($sformatf("halt_strobes_%0d", k), 32'({PCWre, RegWre, mWR, IRWre}), 32'd0);
        @(negedge clk);
      end
      chk("halt_count_unchanged", instr_count, cnt0);
      #2 rst_n = 1'b0;
      #1;
      chk("halt_async_rst_state", 32'(state), 32'd0);
      chk("halt_async_rst_halted", 32'(halted), 32'd0);
      chk("halt_async_rst_count", instr_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end

    // sw interrupted by reset while waiting in MEM
    opcode = 6'b110000;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("sw_mid_state", 32'(state), 32'd3);
    chk("sw_mid_mwr", 32'(mWR), 32'd1);
    @(negedge clk);
    chk("sw_wait_state", 32'(state), 32'd3);
    chk("sw_wait_mwr", 32'(mWR), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("sw_rst_mwr", 32'(mWR), 32'd0);
    chk("sw_rst_state", 32'(state), 32'd0);
    chk("sw_rst_count", instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 6'b000000;
    chk("first_if_state", 32'(state), 32'd0);
    @(negedge clk);
    chk("first_if_one_cycle", 32'(state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
